// File: rtl/load_counter_if.sv
// rtl/load_counter_if.sv - load/enable/data request and count/tc response bundle for load_counter
interface load_counter_if #(
   parameter int WIDTH = 4
) ();
   logic             load;
   logic             enable;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] count;
   logic             tc;

   modport master (
      output load,
      output enable,
      output data,
      input  count,
      input  tc
   );

   modport slave (
      input  load,
      input  enable,
      input  data,
      output count,
      output tc
   );
endinterface

// File: rtl/load_counter.sv
// rtl/load_counter.sv - WIDTH-bit up-counter with parallel load, enable and terminal count
// Define LOAD_COUNTER_ASSERT_EN to compile in simulation-only X/Z checks on the control inputs.
module load_counter #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           reset,
   load_counter_if.slave bus
);
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Load outranks enable; data only matters when load is selected.
   always_comb begin
      count_d = count_q;
      if (bus.load) begin
         count_d = bus.data;
      end else if (bus.enable) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = (&count_q) & bus.enable & ~bus.load & ~reset;

`ifdef LOAD_COUNTER_ASSERT_EN
   always @(posedge clk) begin
      if (reset === 1'b0) begin
         if ($isunknown(bus.load) || $isunknown(bus.enable)) begin
            $error("load_counter: load or enable is X/Z at a clock edge");
         end
         if ((bus.load === 1'b1) && $isunknown(bus.data)) begin
            $error("load_counter: data is X/Z while load is asserted");
         end
      end
   end
`else
   // Checks compiled out; behaviour identical.
`endif
endmodule

// File: tb/tb_load_counter.sv
// tb/tb_load_counter.sv - directed and randomized bench for load_counter
module tb_load_counter;
   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;
   int   cnt;

   load_counter_if #(.WIDTH(W)) bus ();

   load_counter #(.WIDTH(W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic exp_tc();
      return (cnt == MOD - 1) && (bus.enable === 1'b1) && (bus.load === 1'b0) && (reset === 1'b0);
   endfunction

   // Inputs are already applied; check tc, clock once, update the model, check count.
   task automatic cycle(input string tag);
      if (reset === 1'b1) cnt = 0;
      #1;
      chk({tag, "_tc"}, {31'd0, bus.tc}, {31'd0, exp_tc()});
      @(posedge clk);
      if (reset === 1'b1)         cnt = 0;
      else if (bus.load === 1'b1) cnt = int'(bus.data);
      else if (bus.enable === 1'b1) cnt = (cnt + 1) % MOD;
      #1;
      chk({tag, "_count"}, {28'd0, bus.count}, cnt);
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      cnt        = 0;
      reset      = 1'b1;
      bus.load   = 1'bx;
      bus.enable = 1'bx;
      bus.data   = 'x;
      #2;
      chk("reset_async_count", {28'd0, bus.count}, 0);
      chk("reset_async_tc", {31'd0, bus.tc}, 0);
      cycle("reset_x_inputs");

      reset      = 1'b0;
      bus.load   = 1'b0;
      bus.enable = 1'b1;
      for (int i = 0; i < 15; i++) cycle("count_up");
      chk("count_reached_15", {28'd0, bus.count}, 15);

      bus.enable = 1'b0;
      for (int i = 0; i < 15; i++) cycle("hold");

      bus.enable = 1'b1;
      cycle("wrap");
      chk("wrap_zero", {28'd0, bus.count}, 0);

      bus.load   = 1'b1;
      bus.enable = 1'b0;
      for (int i = 15; i >= 1; i--) begin
         bus.data = i[W-1:0];
         cycle("load");
      end

      reset = 1'b1;
      cycle("reset_again");
      reset      = 1'b0;
      bus.enable = 1'b1;
      for (int i = 15; i >= 1; i--) begin
         bus.data = i[W-1:0];
         cycle("load_beats_enable");
      end

      bus.load = 1'b0;
      bus.data = 'x;
      cycle("pre_async");
      cycle("pre_async");
      #2;
      reset = 1'b1;
      #1;
      chk("async_mid_cycle", {28'd0, bus.count}, 0);
      cnt = 0;
      @(negedge clk);
      cycle("async_hold");
      reset = 1'b0;

      for (int i = 0; i < 300; i++) begin
         reset      = ($urandom_range(0, 15) == 0);
         bus.load   = ($urandom_range(0, 3) == 0);
         bus.enable = ($urandom_range(0, 3) != 0);
         bus.data   = W'($urandom);
         cycle("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
